d_mem_lsu: RTL and testbench
============================

# d_mem_lsu

Load/store sequencer that sits directly upstream of `d_mem`. It accepts one load or store request at a time from the execute stage through a valid/ready handshake. Aligned accesses go to `d_mem` as a single access. Misaligned halfword/word accesses are split into sequential byte accesses; the unit reassembles load bytes little-endian and applies sign extension itself.

## Interface
Parameters:
- `AddrWidth`, default 16: byte-address width; matches the `d_mem` address port.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_width`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_sign_extend`  in  1  sign-extend load result.
- `req_addr`  in  AddrWidth  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle completion pulse (loads and stores).
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_misaligned`  out  1  access was split; valid with `rsp_valid`.
- `rsp_error`  out  1  reserved width; valid with `rsp_valid`.
- `mem_addr`  out  AddrWidth  to `d_mem` `addr`.
- `mem_width`  out  2  to `d_mem` `width` (same encoding as `req_width`).
- `mem_sign_extend`  out  1  to `d_mem` `sign_extend`.
- `mem_write_enable`  out  1  to `d_mem` `write_enable`.
- `mem_data_in`  out  32  to `d_mem` `data_in`.
- `mem_data_out`  in  32  from `d_mem` `data_out`; valid the cycle after the address.

## Operation
- **State machine:** IDLE → ISSUE → (WAIT, loads only) → RESP → IDLE.
- **Accept:** in IDLE, `req_valid` high accepts the request. The unit latches all `req_*` fields and loads the access count N.
- **Misalignment:**
  - Half is misaligned when `addr[0]` = 1.
  - Word is misaligned when `addr[1:0]` ≠ 0.
  - Byte is never misaligned.
- **Access count:**
  - Aligned: N = 1.
  - Misaligned half: N = 2.
  - Misaligned word: N = 4.
- **Aligned access:**
  - `mem_width` = `req_width`, `mem_sign_extend` = `req_sign_extend`, `mem_data_in` = `req_wdata`.
  - Load result = `mem_data_out` unchanged (`d_mem` does the extension).
- **Misaligned access, byte k (k = 0..N-1):**
  - `mem_addr` = `req_addr` + k, modulo 2^AddrWidth (wraps).
  - `mem_width` = byte, `mem_sign_extend` = 0.
  - Store: `mem_data_in` = {24'b0, `wdata`[8k+7:8k]}.
  - Load: result[8k+7:8k] = `mem_data_out`[7:0].
  - After the last byte of a half load, bits [31:16] = sign_extend ? {16{result[15]}} : 0.
- **Counter:** a 2-bit byte counter k advances once per ISSUE cycle. ISSUE ends when k = N-1.
- **Reserved width (11):** accepted, no memory access. RESP follows directly with `rsp_error` = 1, `rsp_rdata` = 0.
- **Registered outputs:** all `mem_*` outputs are registered. Outside ISSUE, `mem_write_enable` = 0 and the other `mem_*` outputs hold their last values.
- **Reset values (`reset` low):**
  - State IDLE, `req_ready` = 1, `rsp_valid` = 0.
  - `rsp_rdata`, `rsp_misaligned`, `rsp_error` = 0.
  - `mem_write_enable` = 0, `mem_addr` = 0, `mem_width` = 0, `mem_sign_extend` = 0, `mem_data_in` = 0.

## Timing
- **Acceptance:** handshake in cycle T.
- **Issue:** access k is presented on `mem_*` during cycle T+1+k.
- **Store completion:** last write occurs on the edge ending T+N. `rsp_valid` is high in T+N+1.
- **Load data:** byte/word k data is valid in T+2+k and captured on the edge ending it.
- **Load completion:** `rsp_valid` is high in T+N+2.
  - Aligned load: response at T+3.
  - Misaligned word load: response at T+6.
- **Reserved width:** `rsp_valid` is high in T+1.
- **Busy period:** `req_ready` = 0 from T+1 through the RESP cycle, and returns high the cycle after RESP. Requests presented while busy are ignored and must be held by the requester.
- **Response pulse:** `rsp_valid` is exactly one cycle. `rsp_rdata`, `rsp_misaligned`, `rsp_error` hold until the next RESP.
- **Reset mid-operation:**
  - Asserting `reset` forces IDLE and `mem_write_enable` = 0 immediately (asynchronous).
  - Bytes already written stay written (no rollback), and no response is produced.
  - `req_ready` = 1 in the first cycle after release.

## Test plan
- **Aligned word load:** load word at 0x0010, memory holds 0xDEADBEEF → one access, `mem_width` = 10 at T+1, `rsp_valid` at T+3, `rsp_rdata` = 0xDEADBEEF, `rsp_misaligned` = 0.
- **Misaligned word load:** load word at 0x0011, bytes 0x11..0x14 = AA, BB, CC, DD → byte reads at 0x0011..0x0014 in T+1..T+4, `rsp_valid` at T+6, `rsp_rdata` = 0xDDCCBBAA, `rsp_misaligned` = 1.
- **Misaligned half load:** load half at 0x0003, bytes 0x34, 0x92 → signed gives 0xFFFF9234, unsigned gives 0x00009234, both at T+4.
- **Wrapping store:** store word 0x44332211 at 0xFFFE with AddrWidth = 16 → byte writes 0x11@0xFFFE, 0x22@0xFFFF, 0x33@0x0000, 0x44@0x0001 with `mem_write_enable` high T+1..T+4, `rsp_valid` at T+5.
- **Reset mid-store:** same store as above, `reset` low during T+3 → `mem_write_enable` drops in T+3, only 0xFFFE/0xFFFF are modified, no `rsp_valid`, `req_ready` = 1 after release.
- **Reserved width:** request with `req_width` = 11 → no `mem_write_enable`, `rsp_valid` at T+1 with `rsp_error` = 1, `rsp_rdata` = 0.

Source files
------------

// File: rtl/d_mem_lsu.sv
// Load/store sequencer in front of d_mem: splits misaligned half/word accesses into byte accesses and reassembles loads.
// Latency: store T+N+1, load T+N+2, reserved width T+1; req_ready is high only in IDLE, busy requests must be held.
module d_mem_lsu #(
   parameter int AddrWidth = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [1:0]           req_width,
   input  logic                 req_sign_extend,
   input  logic [AddrWidth-1:0] req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_rdata,
   output logic                 rsp_misaligned,
   output logic                 rsp_error,
   output logic [AddrWidth-1:0] mem_addr,
   output logic [1:0]           mem_width,
   output logic                 mem_sign_extend,
   output logic                 mem_write_enable,
   output logic [31:0]          mem_data_in,
   input  logic [31:0]          mem_data_out
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   localparam logic [1:0] WidthByte = 2'b00;
   localparam logic [1:0] WidthHalf = 2'b01;
   localparam logic [1:0] WidthWord = 2'b10;
   localparam logic [1:0] WidthRsvd = 2'b11;

   state_t               state_q, state_d;
   logic [1:0]           k_q, k_d;
   logic [1:0]           last_q, last_d;
   logic                 write_q, write_d;
   logic [1:0]           width_q, width_d;
   logic                 sext_q, sext_d;
   logic                 mis_q, mis_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [31:0]          acc_q, acc_d;

   logic [AddrWidth-1:0] mem_addr_d;
   logic [1:0]           mem_width_d;
   logic                 mem_sext_d;
   logic                 mem_we_d;
   logic [31:0]          mem_data_in_d;
   logic [31:0]          rsp_rdata_d;
   logic                 rsp_mis_d;
   logic                 rsp_err_d;

   logic                 req_mis;
   logic [1:0]           k_next;
   logic [31:0]          wdata_sh;
   logic [31:0]          load_full;

   function automatic logic is_misaligned(input logic [1:0] w, input logic [1:0] a);
      case (w)
         WidthHalf: is_misaligned = a[0];
         WidthWord: is_misaligned = (a != 2'b00);
         default:   is_misaligned = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] i,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = w;
      r[{i, 3'b000} +: 8] = b;
      return r;
   endfunction

   assign req_mis   = is_misaligned(req_width, req_addr[1:0]);
   assign k_next    = k_q + 2'd1;
   assign wdata_sh  = wdata_q >> {k_next, 3'b000};
   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);

   always_comb begin
      state_d       = state_q;
      k_d           = k_q;
      last_d        = last_q;
      write_d       = write_q;
      width_d       = width_q;
      sext_d        = sext_q;
      mis_d         = mis_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      acc_d         = acc_q;
      mem_addr_d    = mem_addr;
      mem_width_d   = mem_width;
      mem_sext_d    = mem_sign_extend;
      mem_we_d      = 1'b0;
      mem_data_in_d = mem_data_in;
      rsp_rdata_d   = rsp_rdata;
      rsp_mis_d     = rsp_misaligned;
      rsp_err_d     = rsp_error;
      load_full     = put_byte(acc_q, k_q, mem_data_out[7:0]);

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               width_d = req_width;
               sext_d  = req_sign_extend;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               mis_d   = req_mis;
               k_d     = 2'd0;
               acc_d   = 32'd0;
               if (!req_mis)                  last_d = 2'd0;
               else if (req_width == WidthHalf) last_d = 2'd1;
               else                           last_d = 2'd3;
               if (req_width == WidthRsvd) begin
                  state_d     = RESP;
                  rsp_rdata_d = 32'd0;
                  rsp_mis_d   = 1'b0;
                  rsp_err_d   = 1'b1;
               end else begin
                  // First access is registered straight from the request fields.
                  state_d    = ISSUE;
                  mem_addr_d = req_addr;
                  mem_we_d   = req_write;
                  if (req_mis) begin
                     mem_width_d   = WidthByte;
                     mem_sext_d    = 1'b0;
                     mem_data_in_d = {24'd0, req_wdata[7:0]};
                  end else begin
                     mem_width_d   = req_width;
                     mem_sext_d    = req_sign_extend;
                     mem_data_in_d = req_wdata;
                  end
               end
            end
         end
         ISSUE: begin
            // Read data trails the address by one cycle, so byte k-1 lands now.
            if (!write_q && k_q != 2'd0) begin
               acc_d = put_byte(acc_q, k_q - 2'd1, mem_data_out[7:0]);
            end
            if (k_q == last_q) begin
               if (write_q) begin
                  state_d     = RESP;
                  rsp_rdata_d = 32'd0;
                  rsp_mis_d   = mis_q;
                  rsp_err_d   = 1'b0;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               k_d           = k_next;
               mem_addr_d    = addr_q + AddrWidth'(k_next);
               mem_width_d   = WidthByte;
               mem_sext_d    = 1'b0;
               mem_we_d      = write_q;
               mem_data_in_d = {24'd0, wdata_sh[7:0]};
            end
         end
         WAIT: begin
            state_d   = RESP;
            rsp_mis_d = mis_q;
            rsp_err_d = 1'b0;
            if (!mis_q) begin
               rsp_rdata_d = mem_data_out;
            end else begin
               if (width_q == WidthHalf) begin
                  load_full[31:16] = sext_q ? {16{load_full[15]}} : 16'd0;
               end
               rsp_rdata_d = load_full;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         k_q              <= 2'd0;
         last_q           <= 2'd0;
         write_q          <= 1'b0;
         width_q          <= WidthByte;
         sext_q           <= 1'b0;
         mis_q            <= 1'b0;
         addr_q           <= '0;
         wdata_q          <= 32'd0;
         acc_q            <= 32'd0;
         mem_addr         <= '0;
         mem_width        <= WidthByte;
         mem_sign_extend  <= 1'b0;
         mem_write_enable <= 1'b0;
         mem_data_in      <= 32'd0;
         rsp_rdata        <= 32'd0;
         rsp_misaligned   <= 1'b0;
         rsp_error        <= 1'b0;
      end else begin
         state_q          <= state_d;
         k_q              <= k_d;
         last_q           <= last_d;
         write_q          <= write_d;
         width_q          <= width_d;
         sext_q           <= sext_d;
         mis_q            <= mis_d;
         addr_q           <= addr_d;
         wdata_q          <= wdata_d;
         acc_q            <= acc_d;
         mem_addr         <= mem_addr_d;
         mem_width        <= mem_width_d;
         mem_sign_extend  <= mem_sext_d;
         mem_write_enable <= mem_we_d;
         mem_data_in      <= mem_data_in_d;
         rsp_rdata        <= rsp_rdata_d;
         rsp_misaligned   <= rsp_mis_d;
         rsp_error        <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_d_mem_lsu.sv
// Directed bench for d_mem_lsu with a behavioural byte-array d_mem (registered read, little-endian).
module tb_d_mem_lsu;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_width;
   logic        req_sign_extend;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misaligned;
   logic        rsp_error;
   logic [15:0] mem_addr;
   logic [1:0]  mem_width;
   logic        mem_sign_extend;
   logic        mem_write_enable;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out;

   logic [7:0]  mem [0:65535];
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [7:0]  pl_dat;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   d_mem_lsu #(.AddrWidth(16)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_width        (req_width),
      .req_sign_extend  (req_sign_extend),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_rdata        (rsp_rdata),
      .rsp_misaligned   (rsp_misaligned),
      .rsp_error        (rsp_error),
      .mem_addr         (mem_addr),
      .mem_width        (mem_width),
      .mem_sign_extend  (mem_sign_extend),
      .mem_write_enable (mem_write_enable),
      .mem_data_in      (mem_data_in),
      .mem_data_out     (mem_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_rd(input logic [15:0] a, input logic [1:0] w, input logic s);
      logic [7:0] b0, b1, b2, b3;
      b0 = mem[a];
      b1 = mem[a + 16'd1];
      b2 = mem[a + 16'd2];
      b3 = mem[a + 16'd3];
      case (w)
         2'b00:   return s ? {{24{b0[7]}}, b0} : {24'd0, b0};
         2'b01:   return s ? {{16{b1[7]}}, b1, b0} : {16'd0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_dat;
      if (mem_write_enable) begin
         mem[mem_addr] <= mem_data_in[7:0];
         if (mem_width != 2'b00) mem[mem_addr + 16'd1] <= mem_data_in[15:8];
         if (mem_width == 2'b10) begin
            mem[mem_addr + 16'd2] <= mem_data_in[23:16];
            mem[mem_addr + 16'd3] <= mem_data_in[31:24];
         end
      end
      mem_data_out <= mem_rd(mem_addr, mem_width, mem_sign_extend);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_dat  = d;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   task automatic go(input logic w, input logic [1:0] wd, input logic s,
                     input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      chk("ready_before_req", {31'd0, req_ready}, 32'd1);
      req_valid       = 1'b1;
      req_write       = w;
      req_width       = wd;
      req_sign_extend = s;
      req_addr        = a;
      req_wdata       = d;
      @(posedge clk);
      #1 req_valid = 1'b0;
      cyc = 0;
   endtask

   task automatic wait_rsp();
      do tick(); while (!rsp_valid && cyc < 20);
   endtask

   task automatic after_rsp();
      tick();
      chk("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
      chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic seen_rsp;
      reset           = 1'b0;
      req_valid       = 1'b0;
      req_write       = 1'b0;
      req_width       = 2'b00;
      req_sign_extend = 1'b0;
      req_addr        = 16'd0;
      req_wdata       = 32'd0;
      pl_en           = 1'b0;
      pl_addr         = 16'd0;
      pl_dat          = 8'd0;
      #12;
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_flags", {30'd0, rsp_misaligned, rsp_error}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_mem_ctl", {29'd0, mem_width, mem_sign_extend}, 32'd0);
      chk("rst_mem_data", mem_data_in, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // aligned word load
      preload(16'h0010, 8'hEF);
      preload(16'h0011, 8'hBE);
      preload(16'h0012, 8'hAD);
      preload(16'h0013, 8'hDE);
      go(1'b0, 2'b10, 1'b0, 16'h0010, 32'd0);
      tick();
      chk("al_mem_width", {30'd0, mem_width}, 32'd2);
      chk("al_mem_addr", {16'd0, mem_addr}, 32'h10);
      chk("al_busy", {31'd0, req_ready}, 32'd0);
      wait_rsp();
      chk("al_latency", cyc, 32'd3);
      chk("al_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("al_mis", {31'd0, rsp_misaligned}, 32'd0);
      after_rsp();
      chk("al_rdata_hold", rsp_rdata, 32'hDEADBEEF);

      // aligned signed byte load: d_mem extends
      go(1'b0, 2'b00, 1'b1, 16'h0013, 32'd0);
      wait_rsp();
      chk("ab_latency", cyc, 32'd3);
      chk("ab_rdata", rsp_rdata, 32'hFFFFFFDE);
      after_rsp();

      // misaligned word load
      preload(16'h0011, 8'hAA);
      preload(16'h0012, 8'hBB);
      preload(16'h0013, 8'hCC);
      preload(16'h0014, 8'hDD);
      go(1'b0, 2'b10, 1'b1, 16'h0011, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("mw_addr_%0d", i), {16'd0, mem_addr}, 32'h10 + i);
         chk($sformatf("mw_ctl_%0d", i), {29'd0, mem_width, mem_sign_extend}, 32'd0);
      end
      wait_rsp();
      chk("mw_latency", cyc, 32'd6);
      chk("mw_rdata", rsp_rdata, 32'hDDCCBBAA);
      chk("mw_mis", {31'd0, rsp_misaligned}, 32'd1);
      after_rsp();

      // misaligned half loads
      preload(16'h0003, 8'h34);
      preload(16'h0004, 8'h92);
      go(1'b0, 2'b01, 1'b1, 16'h0003, 32'd0);
      wait_rsp();
      chk("mh_s_latency", cyc, 32'd4);
      chk("mh_s_rdata", rsp_rdata, 32'hFFFF9234);
      chk("mh_s_mis", {31'd0, rsp_misaligned}, 32'd1);
      after_rsp();
      go(1'b0, 2'b01, 1'b0, 16'h0003, 32'd0);
      wait_rsp();
      chk("mh_u_latency", cyc, 32'd4);
      chk("mh_u_rdata", rsp_rdata, 32'h00009234);
      after_rsp();

      // wrapping store
      go(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'h44332211);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ws_we_%0d", i), {31'd0, mem_write_enable}, 32'd1);
         chk($sformatf("ws_addr_%0d", i), {16'd0, mem_addr}, {16'd0, 16'hFFFE + 16'(i)});
         chk($sformatf("ws_data_%0d", i), mem_data_in, 32'h11 * (i + 1));
         chk($sformatf("ws_width_%0d", i), {30'd0, mem_width}, 32'd0);
      end
      wait_rsp();
      chk("ws_latency", cyc, 32'd5);
      chk("ws_we_off", {31'd0, mem_write_enable}, 32'd0);
      chk("ws_rdata", rsp_rdata, 32'd0);
      chk("ws_mis", {31'd0, rsp_misaligned}, 32'd1);
      chk("ws_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}, 32'h44332211);
      after_rsp();

      // reset in the middle of the same store
      preload(16'hFFFE, 8'h00);
      preload(16'hFFFF, 8'h00);
      preload(16'h0000, 8'h00);
      preload(16'h0001, 8'h00);
      go(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'h44332211);
      tick();
      tick();
      @(posedge clk);
      #2 reset = 1'b0;
      #1 chk("rm_we_drop", {31'd0, mem_write_enable}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      tick();
      chk("rm_ready", {31'd0, req_ready}, 32'd1);
      seen_rsp = rsp_valid;
      for (int i = 0; i < 8; i++) begin
         tick();
         seen_rsp = seen_rsp | rsp_valid | mem_write_enable;
      end
      chk("rm_no_rsp", {31'd0, seen_rsp}, 32'd0);
      chk("rm_mem", {mem[16'h0001], mem[16'h0000], mem[16'hFFFF], mem[16'hFFFE]}, 32'h00002211);

      // reserved width
      go(1'b1, 2'b11, 1'b0, 16'h0020, 32'hCAFEF00D);
      seen_rsp = mem_write_enable;
      wait_rsp();
      seen_rsp = seen_rsp | mem_write_enable;
      chk("rv_latency", cyc, 32'd1);
      chk("rv_error", {31'd0, rsp_error}, 32'd1);
      chk("rv_rdata", rsp_rdata, 32'd0);
      chk("rv_no_we", {31'd0, seen_rsp}, 32'd0);
      after_rsp();
      chk("rv_error_hold", {31'd0, rsp_error}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
